fetch_unit: RTL and testbench

Instruction-fetch stage for the single-cycle MIPS datapath. Owns the architectural PC register and issues one instruction-memory request at a time over a valid/ready handshake. Holds the returned word for decode and exports `linear_next` (PC+4) to the next-PC adder. On the cycle decode consumes the instruction, it loads the adder's `next_pc` result back into the PC.

---
 rtl/mips_fetch_pkg.sv | 22 ++
 rtl/fetch_unit_if.sv | 35 +++
 rtl/fetch_unit.sv | 85 ++++++++
 tb/tb_fetch_unit.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_fetch_pkg.sv
// Shared types and constants for the MIPS instruction-fetch stage.
package mips_fetch_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'hBFC0_0000;
    localparam logic [XLEN-1:0] PC_STEP          = 32'd4;

    typedef enum logic [1:0] {
        S_BOOT,
        S_REQ,
        S_WAIT,
        S_HOLD
    } fetch_state_e;

    // Instruction word held for decode together with its fault flag.
    typedef struct packed {
        logic [XLEN-1:0] data;
        logic            err;
    } inst_buf_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: instruction-memory request/response plus decode-side hand-off.
interface fetch_unit_if;
    import mips_fetch_pkg::*;

    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_resp_valid;
    logic [XLEN-1:0] imem_resp_data;
    logic            imem_resp_err;
    logic            inst_valid;
    logic            inst_ready;
    logic [XLEN-1:0] inst_data;
    logic [XLEN-1:0] inst_pc;
    logic            inst_err;
    logic [XLEN-1:0] linear_next;
    logic [XLEN-1:0] next_pc;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready,
        input  imem_resp_valid, imem_resp_data, imem_resp_err,
        output inst_valid, inst_data, inst_pc, inst_err, linear_next,
        input  inst_ready, next_pc
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready,
        output imem_resp_valid, imem_resp_data, imem_resp_err,
        input  inst_valid, inst_data, inst_pc, inst_err, linear_next,
        output inst_ready, next_pc
    );

endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues one imem request at a time and
// holds the returned word for decode until it is consumed.
module fetch_unit
    import mips_fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic          clk,
    input  logic          rst_n,
    fetch_unit_if.master  bus
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] linear_next_q, linear_next_d;
    inst_buf_t       buf_q, buf_d;
    logic            req_valid_q, req_valid_d;
    logic            inst_valid_q, inst_valid_d;

    // State, PC and instruction buffer registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_BOOT;
            pc_q          <= RESET_PC;
            linear_next_q <= RESET_PC + PC_STEP;
            buf_q         <= '0;
            req_valid_q   <= 1'b0;
            inst_valid_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            linear_next_q <= linear_next_d;
            buf_q         <= buf_d;
            req_valid_q   <= req_valid_d;
            inst_valid_q  <= inst_valid_d;
        end
    end

    // Next-state and next-register logic; Moore outputs are registered from state_d
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        buf_d   = buf_q;

        case (state_q)
            S_BOOT: state_d = S_REQ;
            S_REQ: begin
                if (bus.imem_req_ready) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (bus.imem_resp_valid) begin
                    buf_d   = '{data: bus.imem_resp_data, err: bus.imem_resp_err};
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (bus.inst_ready) begin
                    pc_d = bus.next_pc;
                    // A misaligned target never reaches memory; it is reported as a fault instead.
                    if (bus.next_pc[1:0] == 2'b00) begin
                        state_d = S_REQ;
                    end else begin
                        buf_d = '{data: '0, err: 1'b1};
                    end
                end
            end
            default: state_d = S_BOOT;
        endcase

        req_valid_d   = (state_d == S_REQ);
        inst_valid_d  = (state_d == S_HOLD);
        linear_next_d = pc_d + PC_STEP;
    end

    assign bus.imem_req_valid = req_valid_q;
    assign bus.imem_req_addr  = {pc_q[XLEN-1:2], 2'b00};
    assign bus.inst_valid     = inst_valid_q;
    assign bus.inst_data      = buf_q.data;
    assign bus.inst_err       = buf_q.err;
    assign bus.inst_pc        = pc_q;
    assign bus.linear_next    = linear_next_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios then randomized traffic
// against a transaction-level model of the fetch stage and its memory.
module tb_fetch_unit;
    import mips_fetch_pkg::*;

    localparam logic [31:0] RST_PC = DEFAULT_RESET_PC;

    logic clk;
    logic rst_n;

    fetch_unit_if bus ();

    fetch_unit #(.RESET_PC(RST_PC)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned total, bad, cyc;

    // Model: what the stage should be showing this cycle.
    logic [31:0] m_pc, m_data, p_addr;
    logic        m_err, m_req, m_inst, m_pend, m_boot, p_err;
    int unsigned p_lat;

    // Directed knobs
    bit          k_rand;
    int unsigned hold_req, hold_inst;
    bit          f_err, f_spur, f_nxt_en;
    logic [31:0] f_nxt;

    int unsigned acc_cyc[$];
    logic [31:0] acc_addr[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h2408_0001;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic check_all();
        check_eq("req_valid", 32'(bus.imem_req_valid), 32'(m_req));
        if (m_req) check_eq("req_addr", bus.imem_req_addr, m_pc);
        check_eq("inst_valid", 32'(bus.inst_valid), 32'(m_inst));
        if (m_inst) begin
            check_eq("inst_data", bus.inst_data, m_data);
            check_eq("inst_err", 32'(bus.inst_err), 32'(m_err));
        end
        check_eq("inst_pc", bus.inst_pc, m_pc);
        check_eq("linear_next", bus.linear_next, m_pc + 32'd4);
    endtask

    task automatic drive_idle();
        bus.imem_req_ready  = 1'b0;
        bus.imem_resp_valid = 1'b0;
        bus.imem_resp_data  = '0;
        bus.imem_resp_err   = 1'b0;
        bus.inst_ready      = 1'b0;
        bus.next_pc         = '0;
    endtask

    // Called at a negedge; leaves the bench at the next negedge.
    task automatic do_reset(input int unsigned n);
        rst_n = 1'b0;
        drive_idle();
        #1;
        m_pc = RST_PC; m_data = '0; m_err = 1'b0;
        m_req = 1'b0; m_inst = 1'b0; m_pend = 1'b0; m_boot = 1'b1;
        acc_cyc.delete();
        acc_addr.delete();
        check_all();
        check_eq("rst_data", bus.inst_data, 32'd0);
        check_eq("rst_err", 32'(bus.inst_err), 32'd0);
        repeat (n) @(negedge clk);
        check_eq("rst_hold_req", 32'(bus.imem_req_valid), 32'd0);
        check_eq("rst_hold_pc", bus.inst_pc, RST_PC);
        rst_n = 1'b1;
        cyc = 0;
    endtask

    // One clock: check, drive inputs for the coming edge, advance the model.
    task automatic step();
        logic        rdy, irdy, rv, re;
        logic [31:0] rd, nxt, tmp;
        check_all();

        rdy = k_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
        if (m_req && hold_req > 0) begin
            rdy = 1'b0;
            hold_req--;
        end

        rv = 1'b0;
        rd = $urandom;
        re = 1'($urandom_range(0, 1));
        if (m_pend) begin
            if (p_lat == 0) begin
                rv = 1'b1;
                rd = mem_word(p_addr);
                re = p_err;
            end
        end else if (f_spur || (k_rand && $urandom_range(0, 7) == 0)) begin
            rv = 1'b1;
            f_spur = 1'b0;
        end

        irdy = k_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
        if (m_inst && hold_inst > 0) begin
            irdy = 1'b0;
            hold_inst--;
        end

        tmp = $urandom;
        nxt = {m_pc[31:2], 2'b00} + 32'd4;
        if (f_nxt_en) nxt = f_nxt;
        else if (k_rand) begin
            case ($urandom_range(0, 9))
                0: nxt = {tmp[31:2], 2'b00};
                1: nxt = {tmp[31:2], 2'b10};
                2: nxt = 32'hFFFF_FFFC;
                default: ;
            endcase
        end

        bus.imem_req_ready  = rdy;
        bus.imem_resp_valid = rv;
        bus.imem_resp_data  = rd;
        bus.imem_resp_err   = re;
        bus.inst_ready      = irdy;
        bus.next_pc         = nxt;

        if (m_boot) begin
            m_boot = 1'b0;
            m_req  = 1'b1;
        end else if (m_req) begin
            if (rdy) begin
                m_req  = 1'b0;
                m_pend = 1'b1;
                p_addr = m_pc;
                p_lat  = k_rand ? $urandom_range(0, 3) : 0;
                p_err  = f_err || (k_rand && $urandom_range(0, 5) == 0);
                f_err  = 1'b0;
                acc_cyc.push_back(cyc);
                acc_addr.push_back(m_pc);
            end
        end else if (m_pend) begin
            if (rv) begin
                m_pend = 1'b0;
                m_inst = 1'b1;
                m_data = rd;
                m_err  = re;
            end else begin
                p_lat--;
            end
        end else if (m_inst && irdy) begin
            f_nxt_en = 1'b0;
            m_pc = nxt;
            if (nxt[1:0] == 2'b00) begin
                m_inst = 1'b0;
                m_req  = 1'b1;
            end else begin
                m_data = '0;
                m_err  = 1'b1;
            end
        end

        @(negedge clk);
        cyc++;
    endtask

    initial begin
        total = 0; bad = 0; cyc = 0;
        k_rand = 1'b0; hold_req = 0; hold_inst = 0;
        f_err = 1'b0; f_spur = 1'b0; f_nxt_en = 1'b0; f_nxt = '0;
        p_lat = 0; p_err = 1'b0; p_addr = '0;
        rst_n = 1'b0;
        drive_idle();
        @(negedge clk);
        do_reset(3);

        // Zero-wait memory, decode always ready, sequential PC
        repeat (12) step();
        if (acc_addr.size() >= 3) begin
            check_eq("first_req_cycle", acc_cyc[0], 32'd1);
            check_eq("acc_addr0", acc_addr[0], 32'hBFC0_0000);
            check_eq("acc_addr1", acc_addr[1], 32'hBFC0_0004);
            check_eq("acc_addr2", acc_addr[2], 32'hBFC0_0008);
            check_eq("acc_gap1", acc_cyc[1] - acc_cyc[0], 32'd3);
            check_eq("acc_gap2", acc_cyc[2] - acc_cyc[1], 32'd3);
        end else begin
            check_eq("acc_count", acc_addr.size(), 32'd3);
        end

        // Back-pressure on both sides
        hold_req = 4; hold_inst = 5;
        repeat (20) step();
        check_eq("holds_used", hold_req + hold_inst, 32'd0);

        // Bus error response, then a clean fetch
        f_err = 1'b1;
        repeat (8) step();

        // Misaligned next_pc: no request, fault held for decode
        f_nxt = 32'h0000_1002; f_nxt_en = 1'b1;
        for (int i = 0; i < 10 && f_nxt_en; i++) step();
        check_eq("mis_req_valid", 32'(bus.imem_req_valid), 32'd0);
        check_eq("mis_inst_valid", 32'(bus.inst_valid), 32'd1);
        check_eq("mis_inst_err", 32'(bus.inst_err), 32'd1);
        check_eq("mis_inst_pc", bus.inst_pc, 32'h0000_1002);
        repeat (6) step();

        // Top-of-memory PC wraps linear_next
        f_nxt = 32'hFFFF_FFFC; f_nxt_en = 1'b1;
        for (int i = 0; i < 10 && f_nxt_en; i++) step();
        check_eq("wrap_linear_next", bus.linear_next, 32'h0000_0000);
        repeat (8) step();

        // Reset while a response is outstanding; stale responses after release are ignored
        for (int i = 0; i < 10 && !m_pend; i++) step();
        check_eq("reached_wait", 32'(m_pend), 32'd1);
        do_reset(2);
        f_spur = 1'b1;
        step();
        f_spur = 1'b1;
        step();
        repeat (10) step();
        if (acc_addr.size() >= 1) check_eq("restart_addr", acc_addr[0], RST_PC);
        else check_eq("restart_count", acc_addr.size(), 32'd1);

        // Randomized traffic with one mid-run reset
        k_rand = 1'b1;
        repeat (1500) step();
        do_reset(1);
        repeat (1500) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
